br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
// - In-flight branch queue downstream of predictor_top: records each issued prediction (addr, torn, GHR snapshot),
//   then retires it in order when the execute stage resolves the branch.
// - Drives predictor_top's update/repair inputs (PAs_up_en, PAs_wr_data, gshare_reen, re_GHR, up_addr).
// - On a mispredict it restores the GHR, flushes all younger entries and stalls new predictions for RECOVER_CYC cycles.
// PARAMETERS
// - DEPTH        8   queue entries; power of two, >=2
// - TAG_W        3   log2(DEPTH); entry index / tag width
// - GHR_W        14  global history width; matches predictor_top GHR_WIDTH
// - ADDR_W       32  branch PC width
// - TGT_W        32  resolved target width; matches TARGET_ADDR
// - RECOVER_CYC  2   stall cycles after a mispredict, >=1
// PORTS
// - clk            in   1       single clock, rising edge
// - reset          in   1       asynchronous, active-low reset
// - pred_valid     in   1       new prediction to enqueue
// - pred_ready     out  1       queue can accept (not full, state NORMAL)
// - pred_addr      in   ADDR_W  branch PC
// - pred_torn      in   1       predicted direction (1 = taken)
// - pred_ghr       in   GHR_W   GHR value used for this prediction
// - pred_tag       out  TAG_W   tag assigned to the entry accepted this cycle (= tail pointer)
// - res_valid      in   1       branch resolved
// - res_tag        in   TAG_W   tag of resolved branch; must equal head tag
// - res_taken      in   1       actual direction
// - res_target     in   TGT_W   actual target
// - PAs_up_en      out  1       one-cycle pulse: update PAs BHT/PST
// - PAs_wr_data    out  1       actual direction for that update
// - gshare_reen    out  1       one-cycle pulse: reload GHR with re_GHR
// - re_GHR         out  GHR_W   repaired history
// - up_addr        out  TGT_W   resolved target of the retiring branch
// - flush          out  1       one-cycle pulse: discard younger front-end work
// - count          out  TAG_W+1 occupied entries, 0..DEPTH
// - res_err        out  1       sticky: res_valid seen when empty or res_tag != head; cleared only by reset
// - stat_commit    out  16      retired branches (optional feature)
// - stat_mispred   out  16      mispredicted branches (optional feature)
// BEHAVIOUR
// - Reset: head=tail=0, count=0, state NORMAL, all outputs 0, pred_tag=0.
// - Storage: circular buffer; head/tail wrap DEPTH-1 -> 0; count tracks occupancy (no extra-bit ambiguity).
// - Enqueue: pred_valid & pred_ready writes {addr,torn,ghr} at tail, tail++.
//   - pred_ready = (count != DEPTH) & (state == NORMAL); combinational, no same-cycle retire bypass.
// - Retire: res_valid & count!=0 & res_tag==head & state==NORMAL pops head.
//   - Otherwise res_valid is ignored and res_err sets.
// - Enqueue and retire in the same cycle: count unchanged, both pointers advance.
// - Update outputs are registered, valid the cycle after retire:
//   - PAs_up_en=1, PAs_wr_data=res_taken, up_addr=res_target.
// - Mispredict = res_taken != stored torn. In the retire cycle, state -> RECOVER and head=tail=count=0.
//   - Any same-cycle enqueue is dropped; pred_tag is not consumed.
//   - Next cycle: gshare_reen=1, flush=1, re_GHR = {ghr[GHR_W-2:0], res_taken}.
// - Correct prediction: gshare_reen=0, flush=0, re_GHR holds its last value.
// - FSM: NORMAL -> RECOVER on mispredict.
//   - RECOVER counts RECOVER_CYC cycles with pred_ready=0 and res ignored (res_err not set).
//   - Then returns to NORMAL.
// - Reset mid-RECOVER returns to NORMAL with an empty queue.
// CONFIGURATION
// - BRQ_STATS_EN defined: stat_commit / stat_mispred count retires / mispredicts.
//   - Saturate at 16'hFFFF; update with the registered update outputs; reset to 0.
// - BRQ_STATS_EN undefined: counters not built; stat_* tied to 16'h0.
// TESTING
// - Enqueue 8 preds (tags 0..7): count=8, pred_ready=0. 9th pred_valid is held off, no write.
// - Retire tag0 correctly (torn=1, taken=1): next cycle PAs_up_en=1, PAs_wr_data=1, gshare_reen=0, count=7.
// - Mispredict: entry ghr=14'h0005, torn=1, taken=0.
//   - Next cycle gshare_reen=1, flush=1, re_GHR=14'h000A, count=0.
//   - pred_ready=0 for 2 cycles, then 1.
// - count=3 with pred_valid and correct res_valid in the same cycle: count stays 3, head and tail both +1.
//   - Repeat across wrap 7->0: tags continue 0,1.
// - res_valid when empty, and res_tag!=head: no update pulse; res_err=1 and stays set until reset.
// - Assert reset (low) during RECOVER: all outputs 0, count=0.
//   - After release, pred_ready=1. With BRQ_STATS_EN, stat_* read 0.

Source files
------------

// File: rtl/br_resolve_queue_if.sv
// ============================================================================
// br_resolve_queue_if
// ----------------------------------------------------------------------------
// Bundles the front-end / execute-stage signals around br_resolve_queue.
//
// Modports
//   slave  : used by the queue itself. It receives predictions and resolutions,
//            and drives the predictor update/repair outputs and status.
//   master : used by the environment (predictor_top glue / testbench).
//
// Signal summary
//   pred_valid/ready/addr/torn/ghr/tag : prediction enqueue handshake
//   res_valid/tag/taken/target         : branch resolution from execute
//   PAs_up_en/PAs_wr_data/up_addr      : registered PAs update
//   gshare_reen/re_GHR/flush           : registered mispredict repair
//   count/res_err                      : occupancy and sticky protocol error
//   stat_commit/stat_mispred           : optional statistics counters
// ============================================================================
interface br_resolve_queue_if #(
    parameter int TAG_W  = 3,
    parameter int GHR_W  = 14,
    parameter int ADDR_W = 32,
    parameter int TGT_W  = 32
);
    // Prediction side
    logic              pred_valid;
    logic              pred_ready;
    logic [ADDR_W-1:0] pred_addr;
    logic              pred_torn;
    logic [GHR_W-1:0]  pred_ghr;
    logic [TAG_W-1:0]  pred_tag;

    // Resolution side
    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic              res_taken;
    logic [TGT_W-1:0]  res_target;

    // Predictor update / repair
    logic              PAs_up_en;
    logic              PAs_wr_data;
    logic              gshare_reen;
    logic [GHR_W-1:0]  re_GHR;
    logic [TGT_W-1:0]  up_addr;
    logic              flush;

    // Status
    logic [TAG_W:0]    count;
    logic              res_err;
    logic [15:0]       stat_commit;
    logic [15:0]       stat_mispred;

    modport slave (
        input  pred_valid, pred_addr, pred_torn, pred_ghr,
        input  res_valid, res_tag, res_taken, res_target,
        output pred_ready, pred_tag,
        output PAs_up_en, PAs_wr_data, gshare_reen, re_GHR, up_addr, flush,
        output count, res_err, stat_commit, stat_mispred
    );

    modport master (
        output pred_valid, pred_addr, pred_torn, pred_ghr,
        output res_valid, res_tag, res_taken, res_target,
        input  pred_ready, pred_tag,
        input  PAs_up_en, PAs_wr_data, gshare_reen, re_GHR, up_addr, flush,
        input  count, res_err, stat_commit, stat_mispred
    );
endinterface

// File: rtl/br_resolve_queue.sv
// ============================================================================
// br_resolve_queue
// ----------------------------------------------------------------------------
// In-flight branch queue sitting downstream of predictor_top. Each accepted
// prediction {addr, torn, ghr} is stored at the tail; branches retire in order
// from the head when execute resolves them. Retirement drives the PAs update
// one cycle later; a mispredict additionally repairs the GHR, flushes all
// younger entries and holds off new predictions for RECOVER_CYC cycles.
//
// Ports
//   clk    : single rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : br_resolve_queue_if.slave (prediction, resolution, update,
//            repair and status signals)
//
// Optional feature
//   BRQ_STATS_EN : when defined, stat_commit / stat_mispred count retired and
//                  mispredicted branches (saturating at 16'hFFFF). When not
//                  defined both read as 16'h0 and no counters are built.
// ============================================================================
module br_resolve_queue #(
    parameter int DEPTH       = 8,
    parameter int TAG_W       = 3,
    parameter int GHR_W       = 14,
    parameter int ADDR_W      = 32,
    parameter int TGT_W       = 32,
    parameter int RECOVER_CYC = 2
) (
    input  logic                clk,
    input  logic                reset,
    br_resolve_queue_if.slave   bus
);

    localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RECOVER_CYC - 1);
    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(DEPTH);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              pas_up_en_q, pas_up_en_d;
    logic              pas_wr_data_q, pas_wr_data_d;
    logic              gshare_reen_q, gshare_reen_d;
    logic              flush_q, flush_d;
    logic [GHR_W-1:0]  re_ghr_q, re_ghr_d;
    logic [TGT_W-1:0]  up_addr_q, up_addr_d;
    logic              res_err_q, res_err_d;

    // Entry storage (no reset needed: entries are only read when occupied)
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic              torn_mem [DEPTH];
    logic [GHR_W-1:0]  ghr_mem  [DEPTH];

    logic [ADDR_W-1:0] head_addr;
    logic              head_torn;
    logic [GHR_W-1:0]  head_ghr;

    logic              pred_ready;
    logic              enq;
    logic              res_ok;
    logic              res_bad;
    logic              mispred;
    logic              wr_en;
    logic              unused_ok;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // Held low while reset is asserted so the front end never sees a ready
    // queue during reset. No same-cycle retire bypass when full.
    assign pred_ready = reset && (count_q != FULL_CNT) && (state_q == ST_NORMAL);
    assign enq        = bus.pred_valid && pred_ready;

    assign res_ok  = bus.res_valid && (count_q != '0) && (bus.res_tag == head_q)
                     && (state_q == ST_NORMAL);
    // Resolutions arriving during RECOVER are silently dropped, not errors.
    assign res_bad = bus.res_valid && (state_q == ST_NORMAL) && !res_ok;

    assign head_addr = addr_mem[head_q];
    assign head_torn = torn_mem[head_q];
    assign head_ghr  = ghr_mem[head_q];

    assign mispred = res_ok && (bus.res_taken != head_torn);

    // A mispredict in the same cycle wipes the queue, so the enqueue is lost.
    assign wr_en = enq && !mispred;

    // The stored PC and the oldest GHR bit have no consumer inside this block;
    // the PC is kept in the entry for debug visibility.
    assign unused_ok = ^{head_addr, head_ghr[GHR_W-1]};

    // ------------------------------------------------------------------------
    // Entry write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem[tail_q] <= bus.pred_addr;
            torn_mem[tail_q] <= bus.pred_torn;
            ghr_mem[tail_q]  <= bus.pred_ghr;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pas_up_en_d   = 1'b0;
        pas_wr_data_d = pas_wr_data_q;
        gshare_reen_d = 1'b0;
        flush_d       = 1'b0;
        re_ghr_d      = re_ghr_q;
        up_addr_d     = up_addr_q;
        res_err_d     = res_err_q | res_bad;

        case (state_q)
            ST_NORMAL: begin
                if (mispred) begin
                    state_d = ST_RECOVER;
                    rc_d    = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end else begin
                    // Pointers wrap naturally: DEPTH is a power of two.
                    if (res_ok) head_d = head_q + 1'b1;
                    if (enq)    tail_d = tail_q + 1'b1;
                    count_d = count_q + {{TAG_W{1'b0}}, enq}
                                      - {{TAG_W{1'b0}}, res_ok};
                end
            end
            ST_RECOVER: begin
                if (rc_q == RC_LAST) begin
                    state_d = ST_NORMAL;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        if (res_ok) begin
            pas_up_en_d   = 1'b1;
            pas_wr_data_d = bus.res_taken;
            up_addr_d     = bus.res_target;
        end

        // Repaired history = snapshot used for the prediction, shifted with
        // the actual outcome of this branch.
        if (mispred) begin
            gshare_reen_d = 1'b1;
            flush_d       = 1'b1;
            re_ghr_d      = {head_ghr[GHR_W-2:0], bus.res_taken};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_NORMAL;
            rc_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            pas_up_en_q   <= 1'b0;
            pas_wr_data_q <= 1'b0;
            gshare_reen_q <= 1'b0;
            flush_q       <= 1'b0;
            re_ghr_q      <= '0;
            up_addr_q     <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            pas_up_en_q   <= pas_up_en_d;
            pas_wr_data_q <= pas_wr_data_d;
            gshare_reen_q <= gshare_reen_d;
            flush_q       <= flush_d;
            re_ghr_q      <= re_ghr_d;
            up_addr_q     <= up_addr_d;
            res_err_q     <= res_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional statistics; they advance on the same edge that raises the
    // registered update outputs.
    // ------------------------------------------------------------------------
`ifdef BRQ_STATS_EN
    logic [15:0] stat_commit_q;
    logic [15:0] stat_mispred_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_commit_q  <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (res_ok && (stat_commit_q != 16'hFFFF)) begin
                stat_commit_q <= stat_commit_q + 16'd1;
            end
            if (mispred && (stat_mispred_q != 16'hFFFF)) begin
                stat_mispred_q <= stat_mispred_q + 16'd1;
            end
        end
    end

    assign bus.stat_commit  = stat_commit_q;
    assign bus.stat_mispred = stat_mispred_q;
`else
    assign bus.stat_commit  = 16'h0;
    assign bus.stat_mispred = 16'h0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.pred_ready  = pred_ready;
    assign bus.pred_tag    = tail_q;
    assign bus.PAs_up_en   = pas_up_en_q;
    assign bus.PAs_wr_data = pas_wr_data_q;
    assign bus.gshare_reen = gshare_reen_q;
    assign bus.re_GHR      = re_ghr_q;
    assign bus.up_addr     = up_addr_q;
    assign bus.flush       = flush_q;
    assign bus.count       = count_q;
    assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_br_resolve_queue.sv
module tb_br_resolve_queue;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    br_resolve_queue_if bus ();

    br_resolve_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pred_valid = 1'b0;
        bus.pred_addr  = '0;
        bus.pred_torn  = 1'b0;
        bus.pred_ghr   = '0;
        bus.res_valid  = 1'b0;
        bus.res_tag    = '0;
        bus.res_taken  = 1'b0;
        bus.res_target = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_count",      bus.count,       0);
        check("rst_ready",      bus.pred_ready,  0);
        check("rst_tag",        bus.pred_tag,    0);
        check("rst_up_en",      bus.PAs_up_en,   0);
        check("rst_reen",       bus.gshare_reen, 0);
        check("rst_flush",      bus.flush,       0);
        check("rst_err",        bus.res_err,     0);
        check("rst_stat_c",     bus.stat_commit, 0);
        reset = 1'b1;
        #2;
        check("post_rst_ready", bus.pred_ready,  1);
        tick();

        // ---------------- fill 8 entries ----------------
        for (int i = 0; i < 8; i++) begin
            bus.pred_valid = 1'b1;
            bus.pred_addr  = 32'h1000 + 32'(i * 4);
            bus.pred_torn  = 1'b1;
            bus.pred_ghr   = (i == 1) ? 14'h0005 : 14'(i);
            check("fill_tag",   bus.pred_tag,   i);
            check("fill_ready", bus.pred_ready, 1);
            tick();
        end
        check("full_count", bus.count,      8);
        check("full_ready", bus.pred_ready, 0);
        check("full_tag",   bus.pred_tag,   0);
        // 9th prediction with the opposite direction: must not overwrite tag 0
        bus.pred_torn = 1'b0;
        bus.pred_ghr  = 14'h3333;
        tick();
        check("ninth_count", bus.count,    8);
        check("ninth_tag",   bus.pred_tag, 0);
        bus.pred_valid = 1'b0;

        // ---------------- correct retire of tag 0 ----------------
        bus.res_valid  = 1'b1;
        bus.res_tag    = 3'd0;
        bus.res_taken  = 1'b1;
        bus.res_target = 32'h0000_0100;
        bus.pred_valid = 1'b1;
        check("full_no_bypass", bus.pred_ready, 0);
        tick();
        bus.res_valid  = 1'b0;
        bus.pred_valid = 1'b0;
        check("ret0_up_en",   bus.PAs_up_en,   1);
        check("ret0_wr_data", bus.PAs_wr_data, 1);
        check("ret0_up_addr", bus.up_addr,     32'h100);
        check("ret0_reen",    bus.gshare_reen, 0);
        check("ret0_flush",   bus.flush,       0);
        check("ret0_count",   bus.count,       7);
        tick();
        check("ret0_pulse_end", bus.PAs_up_en, 0);
        check("ret0_reghr",     bus.re_GHR,    0);

        // ---------------- mispredict on tag 1, enqueue dropped ----------------
        bus.res_valid  = 1'b1;
        bus.res_tag    = 3'd1;
        bus.res_taken  = 1'b0;
        bus.res_target = 32'h0000_0200;
        bus.pred_valid = 1'b1;
        bus.pred_torn  = 1'b1;
        bus.pred_ghr   = 14'h1234;
        check("mis_ready_pre", bus.pred_ready, 1);
        tick();
        bus.pred_valid = 1'b0;
        bus.res_tag    = 3'd0;   // resolution during RECOVER: ignored, no error
        check("mis_reen",    bus.gshare_reen, 1);
        check("mis_flush",   bus.flush,       1);
        check("mis_reghr",   bus.re_GHR,      14'h000A);
        check("mis_count",   bus.count,       0);
        check("mis_up_en",   bus.PAs_up_en,   1);
        check("mis_wr_data", bus.PAs_wr_data, 0);
        check("mis_up_addr", bus.up_addr,     32'h200);
        check("rec1_ready",  bus.pred_ready,  0);
        check("mis_tag",     bus.pred_tag,    0);
        tick();
        bus.res_valid = 1'b0;
        check("rec2_ready",  bus.pred_ready,  0);
        check("rec2_reen",   bus.gshare_reen, 0);
        check("rec2_flush",  bus.flush,       0);
        check("rec2_reghr",  bus.re_GHR,      14'h000A);
        check("rec_no_upd",  bus.PAs_up_en,   0);
        check("rec_no_err",  bus.res_err,     0);
        tick();
        check("rec_done_ready", bus.pred_ready, 1);
        check("rec_done_count", bus.count,      0);

        // ---------------- simultaneous enqueue/retire across wrap ----------------
        for (int i = 0; i < 3; i++) begin
            bus.pred_valid = 1'b1;
            bus.pred_torn  = 1'b0;
            bus.pred_ghr   = 14'(i);
            bus.pred_addr  = 32'h2000 + 32'(i);
            tick();
        end
        check("three_count", bus.count, 3);
        for (int k = 0; k < 9; k++) begin
            bus.pred_valid = 1'b1;
            bus.pred_torn  = 1'b0;
            bus.pred_ghr   = 14'(k + 3);
            bus.res_valid  = 1'b1;
            bus.res_tag    = 3'(k);
            bus.res_taken  = 1'b0;
            bus.res_target = 32'h300 + 32'(k);
            check("sim_tag", bus.pred_tag, (3 + k) % 8);
            tick();
            check("sim_count",   bus.count,     3);
            check("sim_up_en",   bus.PAs_up_en, 1);
            check("sim_up_addr", bus.up_addr,   32'h300 + 32'(k));
            check("sim_reen",    bus.gshare_reen, 0);
        end
        idle_inputs();
        tick();
        check("sim_end_count", bus.count,     3);
        check("sim_end_up_en", bus.PAs_up_en, 0);

        // ---------------- protocol errors ----------------
        // head is now 1; tag 5 is wrong
        bus.res_valid = 1'b1;
        bus.res_tag   = 3'd5;
        tick();
        bus.res_valid = 1'b0;
        check("badtag_up_en", bus.PAs_up_en, 0);
        check("badtag_err",   bus.res_err,   1);
        check("badtag_count", bus.count,     3);
        for (int t = 1; t < 4; t++) begin
            bus.res_valid = 1'b1;
            bus.res_tag   = 3'(t);
            bus.res_taken = 1'b0;
            tick();
            check("drain_up_en", bus.PAs_up_en, 1);
        end
        bus.res_valid = 1'b0;
        tick();
        check("drain_count", bus.count,   0);
        check("err_sticky",  bus.res_err, 1);
        bus.res_valid = 1'b1;
        bus.res_tag   = 3'd4;
        tick();
        bus.res_valid = 1'b0;
        check("empty_up_en", bus.PAs_up_en, 0);
        check("empty_err",   bus.res_err,   1);
        check("empty_count", bus.count,     0);

        // ---------------- reset during RECOVER ----------------
        bus.pred_valid = 1'b1;
        bus.pred_torn  = 1'b1;
        bus.pred_ghr   = 14'h3FFF;
        check("pre_rec_tag", bus.pred_tag, 4);
        tick();
        bus.pred_valid = 1'b0;
        check("pre_rec_count", bus.count, 1);
        bus.res_valid  = 1'b1;
        bus.res_tag    = 3'd4;
        bus.res_taken  = 1'b0;
        bus.res_target = 32'hDEAD_BEEF;
        tick();
        bus.res_valid = 1'b0;
        check("mis2_reen",  bus.gshare_reen, 1);
        check("mis2_reghr", bus.re_GHR,      14'h3FFE);
        check("mis2_ready", bus.pred_ready,  0);
        reset = 1'b0;
        #1;
        check("arst_count",   bus.count,       0);
        check("arst_reen",    bus.gshare_reen, 0);
        check("arst_flush",   bus.flush,       0);
        check("arst_up_en",   bus.PAs_up_en,   0);
        check("arst_wr_data", bus.PAs_wr_data, 0);
        check("arst_reghr",   bus.re_GHR,      0);
        check("arst_up_addr", bus.up_addr,     0);
        check("arst_err",     bus.res_err,     0);
        check("arst_tag",     bus.pred_tag,    0);
        check("arst_ready",   bus.pred_ready,  0);
        check("arst_stat_c",  bus.stat_commit, 0);
        check("arst_stat_m",  bus.stat_mispred, 0);
        #20;
        reset = 1'b1;
        #1;
        check("rel_ready", bus.pred_ready, 1);
        check("rel_count", bus.count,      0);
        bus.pred_valid = 1'b1;
        bus.pred_torn  = 1'b0;
        tick();
        bus.pred_valid = 1'b0;
        check("rel_enq_count", bus.count,      1);
        check("rel_enq_tag",   bus.pred_tag,   1);
        check("rel_enq_ready", bus.pred_ready, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
